// File: rtl/cache_refill_engine.sv
// Line refill engine between the data-cache miss path and main memory.
// Optional victim write-back before the refill is built when WRITE_BACK_EN is defined.
module cache_refill_engine #(
    parameter int OFFSET = 3,
    parameter int LINE_W = 32 * (2 ** OFFSET)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [31:0]       miss_addr,
    input  logic              victim_dirty,
    input  logic [31:0]       victim_addr,
    input  logic [LINE_W-1:0] victim_line,
    output logic              fill_valid,
    output logic [31:0]       fill_addr,
    output logic [LINE_W-1:0] fill_line,
    input  logic              fill_ack,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int              WORDS     = 2 ** OFFSET;
    localparam logic [OFFSET-1:0] LAST    = OFFSET'(WORDS - 1);
    localparam logic [31:0]     LINE_MASK = ~((32'd1 << (OFFSET + 2)) - 32'd1);

    typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

    state_t              state_q, state_d;
    logic [OFFSET-1:0]   k_q, k_d;
    logic [31:0]         base_q, base_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                miss_ready_q, miss_ready_d;
    logic                busy_q, busy_d;
    logic                fill_valid_q, fill_valid_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                accept;
    logic [OFFSET-1:0]   k_next;

`ifdef WRITE_BACK_EN
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         vbase_q, vbase_d;
    logic [LINE_W-1:0]   vline_q, vline_d;
`else
    logic                unused_victim;
    assign unused_victim = ^{victim_dirty, victim_addr, victim_line};
`endif

    // Base is line-aligned, so OR-ing in the word offset never carries.
    function automatic logic [31:0] wordAddr(input logic [31:0] b, input logic [OFFSET-1:0] k);
        return b | (32'(k) << 2);
    endfunction

    assign accept = miss_valid && miss_ready_q;
    assign k_next = k_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            base_q       <= '0;
            line_q       <= '0;
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
`ifdef WRITE_BACK_EN
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            vbase_q      <= '0;
            vline_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            line_q       <= line_d;
            miss_ready_q <= miss_ready_d;
            busy_q       <= busy_d;
            fill_valid_q <= fill_valid_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
`ifdef WRITE_BACK_EN
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            vbase_q      <= vbase_d;
            vline_q      <= vline_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef WRITE_BACK_EN
                    state_d = victim_dirty ? WB : RD;
`else
                    state_d = RD;
`endif
                end
            end
`ifdef WRITE_BACK_EN
            WB:   if (mem_ready && k_q == LAST) state_d = RD;
`endif
            RD:   if (mem_ready && k_q == LAST) state_d = FILL;
            FILL: if (fill_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath are computed one cycle ahead from the next state.
    always_comb begin
        k_d          = k_q;
        base_d       = base_q;
        line_d       = line_q;
        fill_valid_d = fill_valid_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
`ifdef WRITE_BACK_EN
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        vbase_d      = vbase_q;
        vline_d      = vline_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d     = miss_addr & LINE_MASK;
                    k_d        = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = miss_addr & LINE_MASK;
`ifdef WRITE_BACK_EN
                    vbase_d     = victim_addr & LINE_MASK;
                    vline_d     = victim_line;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    if (victim_dirty) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = victim_addr & LINE_MASK;
                        mem_wdata_d = victim_line[31:0];
                    end
`endif
                end
            end
`ifdef WRITE_BACK_EN
            WB: begin
                if (mem_ready) begin
                    if (k_q == LAST) begin
                        k_d         = '0;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_addr_d  = base_q;
                    end else begin
                        k_d         = k_next;
                        mem_addr_d  = wordAddr(vbase_q, k_next);
                        mem_wdata_d = vline_q[32*int'(k_next) +: 32];
                    end
                end
            end
`endif
            RD: begin
                if (mem_ready) begin
                    line_d[32*int'(k_q) +: 32] = mem_rdata;
                    if (k_q == LAST) begin
                        k_d          = '0;
                        mem_req_d    = 1'b0;
                        mem_addr_d   = '0;
                        fill_valid_d = 1'b1;
                    end else begin
                        k_d        = k_next;
                        mem_addr_d = wordAddr(base_q, k_next);
                    end
                end
            end
            FILL: if (fill_ack) fill_valid_d = 1'b0;
            default: ;
        endcase
        miss_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    assign miss_ready = miss_ready_q;
    assign busy       = busy_q;
    assign fill_valid = fill_valid_q;
    assign fill_addr  = base_q;
    assign fill_line  = line_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
`ifdef WRITE_BACK_EN
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
`else
    assign mem_we     = 1'b0;
    assign mem_wdata  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_engine.sv
// Scoreboard bench for cache_refill_engine: a memory responder and a cache-side
// responder pop expected transactions and fills pushed by the stimulus process.
module tb_cache_refill_engine;

    localparam int OFFSET = 3;
    localparam int WORDS  = 2 ** OFFSET;
    localparam int LW     = 32 * WORDS;

    logic          clk;
    logic          reset;
    logic          miss_valid;
    logic          miss_ready;
    logic [31:0]   miss_addr;
    logic          victim_dirty;
    logic [31:0]   victim_addr;
    logic [LW-1:0] victim_line;
    logic          fill_valid;
    logic [31:0]   fill_addr;
    logic [LW-1:0] fill_line;
    logic          fill_ack;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    cache_refill_engine #(.OFFSET(OFFSET)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line), .fill_ack(fill_ack),
        .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memTxn_t;

    memTxn_t       memQ[$];
    logic [31:0]   fillAddrQ[$];
    logic [LW-1:0] fillLineQ[$];

    int errors = 0;
    int checks = 0;
    int readsDone = 0;
    int fixedLat = 0;
    int ackDelay = 0;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return ((a & 32'hFFFF_FFE0) << 8) | (32'h0000_00A0 + {29'd0, a[4:2]});
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("resetMem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
        checkOutput("resetFill", {fill_valid, fill_addr}, '0);
        checkOutput("resetLine", fill_line, '0);
        checkOutput("resetCtl", {miss_ready, busy}, '0);
    endtask

    // Called at a negedge; pushes the expected traffic just before the accepting edge.
    task automatic applyStimulus(input logic [31:0] maddr, input logic dirty,
                                 input logic [31:0] vaddr, input logic [LW-1:0] vline);
        int n;
        logic [31:0] base;
        logic [31:0] vbase;
        logic [LW-1:0] line;
        miss_valid   = 1'b1;
        miss_addr    = maddr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        victim_line  = vline;
        n = 0;
        while (!miss_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!miss_ready) begin
            checkOutput("missAcceptTimeout", 1'b0, 1'b1);
        end else begin
            base  = maddr & ~32'(WORDS * 4 - 1);
            vbase = vaddr & ~32'(WORDS * 4 - 1);
`ifdef WRITE_BACK_EN
            if (dirty)
                for (int k = 0; k < WORDS; k++)
                    memQ.push_back('{1'b1, vbase + 32'(4 * k), vline[32*k +: 32]});
`endif
            for (int k = 0; k < WORDS; k++) begin
                memQ.push_back('{1'b0, base + 32'(4 * k), 32'd0});
                line[32*k +: 32] = memData(base + 32'(4 * k));
            end
            fillAddrQ.push_back(base);
            fillLineQ.push_back(line);
            @(posedge clk);
        end
    endtask

    task automatic waitFill(output int cycles);
        int n;
        cycles = 0;
        do begin
            @(negedge clk);
            miss_valid = 1'b0;
            cycles++;
        end while (!fill_valid && cycles < 500);
        if (!fill_valid) checkOutput("fillTimeout", 1'b0, 1'b1);
        n = 0;
        while (fill_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (fill_valid) checkOutput("fillAckTimeout", 1'b0, 1'b1);
    endtask

    // Memory responder and transaction monitor.
    logic          pendingValid = 1'b0;
    logic [31:0]   pAddr, pWdata;
    logic          pWe;
    int            waited, curLat;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
    end
    always @(negedge clk) begin
        memTxn_t e;
        if (!reset) begin
            mem_ready    = 1'b0;
            pendingValid = 1'b0;
            waited       = 0;
        end else if (mem_req) begin
            if (pendingValid) begin
                checkOutput("memStable", {mem_we, mem_addr, mem_wdata}, {pWe, pAddr, pWdata});
                waited++;
            end else begin
                pendingValid = 1'b1;
                pWe = mem_we; pAddr = mem_addr; pWdata = mem_wdata;
                waited = 0;
                curLat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
            end
            if (waited >= curLat) begin
                mem_ready    = 1'b1;
                pendingValid = 1'b0;
                if (memQ.size() == 0) begin
                    checkOutput("memUnexpected", {mem_we, mem_addr}, '0);
                end else begin
                    e = memQ.pop_front();
                    checkOutput("memWe", mem_we, e.we);
                    checkOutput("memAddr", mem_addr, e.addr);
                    if (e.we) checkOutput("memWdata", mem_wdata, e.wdata);
                    else readsDone++;
                end
                mem_rdata = mem_we ? $urandom() : memData(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom();
            end
        end else begin
            if (pendingValid) checkOutput("memAbandoned", 1'b0, 1'b1);
            pendingValid = 1'b0;
            mem_ready    = 1'($urandom_range(0, 1));
            mem_rdata    = $urandom();
        end
    end

    // Cache-side responder and fill monitor.
    logic          prevFv = 1'b0;
    logic          prevAck = 1'b0;
    logic [LW-1:0] heldLine;
    logic [31:0]   heldAddr;
    int            fillWait, curAck;
    initial fill_ack = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prevFv   = 1'b0;
            prevAck  = 1'b0;
            fill_ack = 1'b0;
        end else begin
            if (fill_valid) begin
                if (!prevFv) begin
                    if (fillAddrQ.size() == 0) begin
                        checkOutput("fillUnexpected", 1'b1, 1'b0);
                    end else begin
                        checkOutput("fillAddr", fill_addr, fillAddrQ.pop_front());
                        checkOutput("fillLine", fill_line, fillLineQ.pop_front());
                    end
                    heldLine = fill_line;
                    heldAddr = fill_addr;
                    fillWait = 0;
                    curAck   = (ackDelay >= 0) ? ackDelay : int'($urandom_range(0, 3));
                end else begin
                    checkOutput("fillLineHeld", fill_line, heldLine);
                    checkOutput("fillAddrHeld", fill_addr, heldAddr);
                    checkOutput("fillDropAfterAck", prevAck, 1'b0);
                end
                checkOutput("missReadyInFill", miss_ready, 1'b0);
                checkOutput("busyInFill", busy, 1'b1);
                checkOutput("memReqInFill", mem_req, 1'b0);
                fill_ack = (fillWait >= curAck);
                fillWait++;
            end else begin
                if (prevAck) checkOutput("missReadyAfterAck", miss_ready, 1'b1);
                fill_ack = 1'($urandom_range(0, 1));
            end
            prevAck = fill_valid && fill_ack;
            prevFv  = fill_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int target;
        logic [LW-1:0] vline;
        reset        = 1'b0;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_addr  = '0;
        victim_line  = '0;

        repeat (3) begin
            @(negedge clk);
            checkResetOutputs();
        end
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("missReadyAfterReset", miss_ready, 1'b1);
        checkOutput("idleAfterReset", {busy, mem_req, fill_valid}, '0);

        // Zero-wait memory: eight back-to-back reads then fill.
        fixedLat = 0; ackDelay = 0;
        applyStimulus(32'h0000_1234, 1'b0, 32'h0, '0);
        waitFill(lat);
        checkOutput("latencyTied", 32'(lat), 32'(WORDS + 1));

        // Three wait cycles per word.
        @(negedge clk);
        fixedLat = 3;
        applyStimulus(32'h0000_5678, 1'b0, 32'h0, '0);
        waitFill(lat);
        checkOutput("latencyWait3", 32'(lat), 32'(4 * WORDS + 1));

        // Slow fill acknowledge.
        @(negedge clk);
        fixedLat = 0; ackDelay = 5;
        applyStimulus(32'hDEAD_BEEC, 1'b0, 32'h0, '0);
        waitFill(lat);

        // Reset in the middle of a refill.
        @(negedge clk);
        fixedLat = 1; ackDelay = 0;
        target = readsDone + 3;
        applyStimulus(32'h0000_3000, 1'b0, 32'h0, '0);
        n = 0;
        while (readsDone < target && n < 200) begin
            @(negedge clk);
            miss_valid = 1'b0;
            n++;
        end
        checkOutput("partialReads", 32'(readsDone >= target), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 checkResetOutputs();
        memQ.delete();
        fillAddrQ.delete();
        fillLineQ.delete();
        miss_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("missReadyAfterMidReset", miss_ready, 1'b1);
        applyStimulus(32'h0000_4000, 1'b0, 32'h0, '0);
        waitFill(lat);
        checkOutput("latencyAfterReset", 32'(lat), 32'(2 * WORDS + 1));

        // Dirty victim: written back first when the feature is built, ignored otherwise.
        @(negedge clk);
        fixedLat = 0;
        for (int k = 0; k < WORDS; k++) vline[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
        applyStimulus(32'h0000_8000, 1'b1, 32'h0000_2010, vline);
        waitFill(lat);

        // Randomised misses, random latencies, back-to-back requests.
        fixedLat = -1; ackDelay = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < WORDS; k++) vline[32*k +: 32] = $urandom();
            applyStimulus($urandom(), 1'($urandom_range(0, 1)), $urandom(), vline);
            if ($urandom_range(0, 1) == 1) waitFill(lat);
        end
        @(negedge clk);
        miss_valid = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainIdle", busy, 1'b0);
        checkOutput("memQueueEmpty", 32'(memQ.size()), 32'd0);
        checkOutput("fillQueueEmpty", 32'(fillAddrQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
